cla_tree_adder: RTL and testbench

Pipelined, parametrised multi-operand adder that reduces `N` operands of `W` bits to one exact sum through a binary tree of carry-lookahead adders, one register stage per tree level. It generalises the team's single-pair CLA in four ways: operand count, group-lookahead size, signed/unsigned mode, and valid/ready streaming with backpressure. It sits between operand producers and the accumulation/reporting logic of the multi-operand adder datapath.

---
 rtl/cla_pkg.sv | 64 ++++++
 rtl/cla_group_adder.sv | 72 +++++++
 rtl/cla_tree_adder.sv | 114 +++++++++++
 tb/tb_cla_tree_adder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead tree adder: log2 helper,
// group propagate/generate helpers and default sizing constants.
package cla_pkg;

  // Widest lookahead group the helper functions can evaluate.
  localparam int MAX_GRP = 64;

  // Ceiling log2 for elaboration-time sizing (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Number of lookahead groups covering 'width' bits; the last may be partial.
  function automatic int grp_count(input int width, input int grp);
    return (width + grp - 1) / grp;
  endfunction

  // Output width of an n-operand tree over w-bit operands.
  function automatic int out_width(input int w, input int n);
    return w + clog2(n);
  endfunction

  // Group generate over the low n bits: carry out of those bits with carry-in 0.
  function automatic logic grp_gen(input logic [MAX_GRP-1:0] g,
                                   input logic [MAX_GRP-1:0] p,
                                   input int n);
    logic c;
    c = 1'b0;
    for (int i = 0; i < MAX_GRP; i++) begin
      if (i < n) begin
        c = g[i] | (p[i] & c);
      end
    end
    return c;
  endfunction

  // Group propagate over the low n bits: carry-in passes straight through.
  function automatic logic grp_prop(input logic [MAX_GRP-1:0] p, input int n);
    logic pr;
    pr = 1'b1;
    for (int i = 0; i < MAX_GRP; i++) begin
      if (i < n) begin
        pr = pr & p[i];
      end
    end
    return pr;
  endfunction

  // Default configuration of the tree.
  localparam int DEF_W     = 16;
  localparam int DEF_N     = 8;
  localparam int DEF_GRP   = 4;
  localparam int DEF_L     = clog2(DEF_N);
  localparam int DEF_OUT_W = out_width(DEF_W, DEF_N);
  localparam int DEF_NG    = grp_count(DEF_OUT_W, DEF_GRP);

endpackage

// File: rtl/cla_group_adder.sv
// Combinational grouped carry-lookahead adder, carry-in 0, no carry-out.
// Group carries ripple from group to group; inside a group every bit's
// carry is a direct lookahead from the group carry-in.
module cla_group_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GRP   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);

  localparam int NG = grp_count(WIDTH, GRP);
  localparam int PW = NG * GRP;

  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] c_s;
  logic [PW-1:0]    p_pad_s;
  logic [PW-1:0]    g_pad_s;
  logic [NG-1:0]    gc_s;

  assign p_s = a ^ b;
  assign g_s = a & b;

  // Zero-pad propagate/generate so a partial last group looks like a full one.
  always_comb begin
    p_pad_s = '0;
    g_pad_s = '0;
    p_pad_s[WIDTH-1:0] = p_s;
    g_pad_s[WIDTH-1:0] = g_s;
  end

  // Carry into each group: ripple of group-level P/G, starting from carry-in 0.
  always_comb begin
    logic [MAX_GRP-1:0] gg_v;
    logic [MAX_GRP-1:0] gp_v;
    gg_v = '0;
    gp_v = '0;
    gc_s = '0;
    gc_s[0] = 1'b0;
    for (int j = 1; j < NG; j++) begin
      gg_v = '0;
      gp_v = '0;
      gg_v[GRP-1:0] = g_pad_s[(j-1)*GRP +: GRP];
      gp_v[GRP-1:0] = p_pad_s[(j-1)*GRP +: GRP];
      gc_s[j] = grp_gen(gg_v, gp_v, GRP) | (grp_prop(gp_v, GRP) & gc_s[j-1]);
    end
  end

  // Per-bit carry: lookahead over the lower bits of its own group.
  always_comb begin
    logic [MAX_GRP-1:0] gg_v;
    logic [MAX_GRP-1:0] gp_v;
    gg_v = '0;
    gp_v = '0;
    c_s  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gg_v = '0;
      gp_v = '0;
      gg_v[GRP-1:0] = g_pad_s[(i/GRP)*GRP +: GRP];
      gp_v[GRP-1:0] = p_pad_s[(i/GRP)*GRP +: GRP];
      c_s[i] = grp_gen(gg_v, gp_v, i % GRP) |
               (grp_prop(gp_v, i % GRP) & gc_s[i/GRP]);
    end
  end

  assign s = p_s ^ c_s;

endmodule

// File: rtl/cla_tree_adder.sv
// Pipelined N-operand adder: a binary tree of grouped CLAs with one
// register stage per level, valid/ready streaming and per-bundle
// signed/unsigned mode. All stages freeze together on output backpressure.
module cla_tree_adder
  import cla_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int N   = DEF_N,
  parameter int GRP = DEF_GRP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*W-1:0]         operands,
  input  logic                   signed_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W+clog2(N)-1:0]  sum
);

  localparam int L     = clog2(N);
  localparam int OUT_W = W + L;
  localparam int BASE  = N * W;

  // Bit offset of tree level 'lvl' inside the flat data register. Level j
  // holds N>>j partial sums of W+j bits each, packed lowest node first.
  function automatic int lvl_off(input int lvl);
    int o;
    o = 0;
    for (int j = 0; j <= L; j++) begin
      if (j < lvl) begin
        o = o + (N >> j) * (W + j);
      end
    end
    return o;
  endfunction

  localparam int TOT = lvl_off(L + 1);

  logic [TOT-1:0] data_r;
  logic [TOT-1:0] data_nxt_s;
  logic [L:0]     valid_r;
  logic [L-1:0]   mode_r;
  logic           stall_s;
  logic           accept_s;

  // A held result blocks the whole pipeline; nothing enters while stalled
  // or in reset.
  assign stall_s   = valid_r[L] & ~out_ready;
  assign in_ready  = ~stall_s & ~rst;
  assign accept_s  = in_valid & in_ready;
  assign out_valid = valid_r[L];
  assign sum       = data_r[TOT-1 -: OUT_W];

  // Level 0 captures the operand bundle only when it is actually accepted.
  assign data_nxt_s[BASE-1:0] = accept_s ? operands : data_r[BASE-1:0];

  // Levels 1..L: extend each pair by one bit according to the bundle's mode,
  // add, and load the result only when the feeding stage carries a valid bundle.
  generate
    for (genvar l = 1; l <= L; l++) begin : g_lvl
      for (genvar k = 0; k < (N >> l); k++) begin : g_node
        localparam int AW = W + l - 1;
        localparam int IA = lvl_off(l - 1) + (2 * k) * AW;
        localparam int IB = IA + AW;
        localparam int OO = lvl_off(l) + k * (W + l);

        logic [AW:0] a_ext_s;
        logic [AW:0] b_ext_s;
        logic [AW:0] s_s;

        assign a_ext_s = {mode_r[l-1] & data_r[IA+AW-1], data_r[IA +: AW]};
        assign b_ext_s = {mode_r[l-1] & data_r[IB+AW-1], data_r[IB +: AW]};

        cla_group_adder #(
          .WIDTH (W + l),
          .GRP   (GRP)
        ) u_add (
          .a (a_ext_s),
          .b (b_ext_s),
          .s (s_s)
        );

        assign data_nxt_s[OO +: (W + l)] = valid_r[l-1] ? s_s : data_r[OO +: (W + l)];
      end
    end
  endgenerate

  // Pipeline registers: clear on reset, freeze on stall, otherwise advance
  // every stage (bubbles included) by one level.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= '0;
      valid_r <= '0;
      mode_r  <= '0;
    end else if (!stall_s) begin
      data_r     <= data_nxt_s;
      valid_r[0] <= accept_s;
      mode_r[0]  <= signed_mode;
      for (int l = 1; l <= L; l++) begin
        valid_r[l] <= valid_r[l-1];
      end
      for (int l = 1; l < L; l++) begin
        mode_r[l] <= mode_r[l-1];
      end
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
      mode_r  <= mode_r;
    end
  end

endmodule

// File: tb/tb_cla_tree_adder.sv
// Directed and scoreboard checks for cla_tree_adder (default 8x16 instance
// plus a 4x13 instance with a partial lookahead group).
module tb_cla_tree_adder;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] operands;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [18:0]  sum;

  logic         in_valid_p;
  logic         in_ready_p;
  logic [51:0]  operands_p;
  logic         signed_mode_p;
  logic         out_valid_p;
  logic         out_ready_p;
  logic [14:0]  sum_p;

  int n_checks;
  int n_errors;

  cla_tree_adder #(.W(16), .N(8), .GRP(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operands    (operands),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum)
  );

  cla_tree_adder #(.W(13), .N(4), .GRP(4)) dut_p (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid_p),
    .in_ready    (in_ready_p),
    .operands    (operands_p),
    .signed_mode (signed_mode_p),
    .out_valid   (out_valid_p),
    .out_ready   (out_ready_p),
    .sum         (sum_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ops;
    logic         mode;
    logic [18:0]  exp;
    string        name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rep(input int k);
    logic [15:0] v;
    v = 16'(k);
    return {8{v}};
  endfunction

  // Reference: extend each operand to 19 bits by mode and add.
  function automatic logic [18:0] ref_sum(input logic [127:0] ops, input logic m);
    logic [18:0] acc;
    logic [15:0] op;
    acc = 19'd0;
    for (int k = 0; k < 8; k++) begin
      op = ops[k*16 +: 16];
      acc = acc + (m ? {{3{op[15]}}, op} : {3'b000, op});
    end
    return acc;
  endfunction

  // One isolated bundle: check acceptance, latency of 3 edges and the sum.
  task automatic run_bundle(input logic [127:0] ops, input logic m,
                            input logic [18:0] exp, input string nm);
    int lat;
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    operands    = ops;
    signed_mode = m;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd3);
    check({nm, "_sum"}, 32'(sum), 32'(exp));
  endtask

  // One bundle on the partial-group instance (latency 2 edges).
  task automatic run_p(input logic [51:0] ops, input logic m,
                       input logic [14:0] exp, input string nm);
    int lat;
    operands_p    = ops;
    signed_mode_p = m;
    in_valid_p    = 1'b1;
    @(posedge clk); #1;
    in_valid_p = 1'b0;
    lat = 0;
    while (!out_valid_p && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd2);
    check({nm, "_sum"}, 32'(sum_p), 32'(exp));
  endtask

  initial begin
    logic [127:0] alt;
    logic [18:0]  e;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    operands = '0;
    signed_mode = 1'b0;
    out_ready = 1'b1;
    in_valid_p = 1'b0;
    operands_p = '0;
    signed_mode_p = 1'b0;
    out_ready_p = 1'b1;

    alt = {4{16'h0001, 16'hFFFF}};
    vecs[0] = '{ops: {8{16'hFFFF}}, mode: 1'b0, exp: 19'h7FFF8, name: "all_ffff_u"};
    vecs[1] = '{ops: alt,           mode: 1'b1, exp: 19'h00000, name: "alt_s"};
    vecs[2] = '{ops: alt,           mode: 1'b0, exp: 19'h40000, name: "alt_u"};
    vecs[3] = '{ops: {8{16'h8000}}, mode: 1'b1, exp: 19'h40000, name: "all_8000_s"};
    vecs[4] = '{ops: {8{16'h8000}}, mode: 1'b0, exp: 19'h40000, name: "all_8000_u"};
    vecs[5] = '{ops: {8{16'h7FFF}}, mode: 1'b1, exp: 19'h3FFF8, name: "all_7fff_s"};
    vecs[6] = '{ops: 128'h0007_0006_0005_0004_0003_0002_0001_0000, mode: 1'b0,
                exp: 19'h0001C, name: "ramp_u"};
    vecs[7] = '{ops: 128'h0, mode: 1'b1, exp: 19'h00000, name: "zeros_s"};
    vecs[8] = '{ops: {8{16'hFFFF}}, mode: 1'b1, exp: 19'h7FFF8, name: "all_ffff_s"};
    vecs[9] = '{ops: 128'h0001_0001_0001_0001_0001_0001_0001_8000, mode: 1'b1,
                exp: 19'h78007, name: "min_plus_ones_s"};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_out_valid_p", 32'(out_valid_p), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table of isolated bundles
    for (int i = 0; i < 10; i++) begin
      run_bundle(vecs[i].ops, vecs[i].mode, vecs[i].exp, vecs[i].name);
    end

    // Mode split: same data, signed then unsigned, back-to-back
    operands = alt;
    signed_mode = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    signed_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("split_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("split_s_valid", 32'(out_valid), 32'd1);
    check("split_s_sum", 32'(sum), 32'h00000);
    @(posedge clk); #1;
    check("split_u_valid", 32'(out_valid), 32'd1);
    check("split_u_sum", 32'(sum), 32'h40000);
    @(posedge clk); #1;
    check("split_drained", 32'(out_valid), 32'd0);

    // Streaming with a 2-cycle stall while 16 is presented
    for (int k = 1; k <= 5; k++) begin
      operands = rep(k);
      signed_mode = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (k == 4) begin
        check("stream_sum_8", 32'(sum), 32'd8);
      end
    end
    in_valid = 1'b0;
    check("stream_sum_16", 32'(sum), 32'd16);
    out_ready = 1'b0;
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      check("stall_hold_sum", 32'(sum), 32'd16);
      check("stall_hold_valid", 32'(out_valid), 32'd1);
      check("stall_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      @(posedge clk); #1;
      check("stream_after_stall_valid", 32'(out_valid), 32'd1);
      check("stream_after_stall_sum", 32'(sum), 32'(8 * k));
    end
    @(posedge clk); #1;
    check("stream_drained", 32'(out_valid), 32'd0);

    // Reset while two bundles are in flight
    operands = rep(3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("midrst_no_ghost", 32'(out_valid), 32'd0);
    end
    run_bundle(rep(1), 1'b0, 19'd8, "post_reset");

    // Partial lookahead group instance
    run_p({13'h0001, 13'h1000, 13'h0FFF, 13'h0FFF}, 1'b1, 15'h0FFF, "partial_s");
    run_p({13'h0000, 13'h0000, 13'h0001, 13'h1FFF}, 1'b0, 15'h2000, "partial_u");
    run_p({13'h0000, 13'h0000, 13'h0001, 13'h1FFF}, 1'b1, 15'h0000, "partial_s0");

    // Random regression against the reference model with random backpressure
    begin
      logic [18:0] exp_q[$];
      for (int c = 0; c < 6000; c++) begin
        in_valid    = ($urandom_range(0, 9) < 7);
        signed_mode = 1'($urandom_range(0, 1));
        out_ready   = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 8; k++) begin
          case ($urandom_range(0, 3))
            0: operands[k*16 +: 16] = 16'hFFFF;
            1: operands[k*16 +: 16] = 16'h8000;
            2: operands[k*16 +: 16] = 16'h7FFF;
            default: operands[k*16 +: 16] = 16'($urandom);
          endcase
        end
        #1;
        if (in_valid && in_ready) exp_q.push_back(ref_sum(operands, signed_mode));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rand_spurious: got output 0x%0h, expected none", sum);
          end else begin
            e = exp_q.pop_front();
            check("rand_sum", 32'(sum), 32'(e));
          end
        end
        @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rand_spurious: got output 0x%0h, expected none", sum);
          end else begin
            e = exp_q.pop_front();
            check("rand_drain_sum", 32'(sum), 32'(e));
          end
        end
        @(posedge clk); #1;
      end
      check("rand_leftover", 32'(exp_q.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
